fpu_operand_loader: RTL and testbench
=====================================

Name: fpu_operand_loader

Overview:
- Input stage directly upstream of the FPU adder.
- Receives two IEEE-754 single-precision operands as a byte stream over a valid/ready handshake.
- Converts each operand to the FPU's internal word format: sign[31], exp[30:25] with bias 31, mant[24:0] with an implicit leading 1.
- Presents the converted pair on op_A_out/op_B_out and holds it stable for a fixed window, so the FPU's variable-length iteration (normalization loop included) completes on constant operands.

Parameters:
- HOLD_CYCLES, 32: cycles op_valid stays high. Must be ≥ the worst-case FPU iteration of 4 + 27 normalization cycles.
- BYTES_PER_OP, 4: bytes per IEEE operand. Fixed; exposed for the bench only.

Ports:
- clock100KHz  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- in_byte  in  8  operand byte stream, MSB first, A then B
- in_valid  in  1  in_byte is valid
- in_ready  out  1  loader accepts a byte this cycle
- op_A_out  out  32  converted operand A, drives FPU op_A_in
- op_B_out  out  32  converted operand B, drives FPU op_B_in
- op_valid  out  1  operands fresh and held stable
- conv_status  out  4  one-hot: 0001 exact, 0100 overflow, 1000 underflow
- busy  out  1  high in CONVERT or HOLD

Behaviour:
- Reset (asynchronous, active-high), takes effect immediately, including mid-operation:
  - state=COLLECT, byte count=0, partial shift registers cleared
  - op_A_out=0, op_B_out=0, op_valid=0, conv_status=0000, busy=0
  - in_ready=1 from the first clock after reset deasserts
- State machine:
  - COLLECT: in_ready=1. A byte is taken on each edge with in_valid&&in_ready.
    - Bytes 0-3 shift into A (byte 0 → bits 31:24); bytes 4-7 shift into B the same way.
    - Accepting byte 7 moves to CONVERT.
    - in_valid low: no shift, count held.
  - CONVERT: exactly 1 cycle, in_ready=0.
    - Registers op_A_out, op_B_out and conv_status; sets op_valid=1 and the hold counter to HOLD_CYCLES-1; moves to HOLD.
  - HOLD: in_ready=0, op_valid=1. Offered bytes are ignored and not buffered.
    - Counter decrements each cycle; at 0 the state returns to COLLECT and op_valid drops.
- Latency:
  - Byte 7 accepted at edge N; outputs updated and op_valid=1 at edge N+1.
  - op_valid is high for exactly HOLD_CYCLES cycles.
  - in_ready returns to 1 HOLD_CYCLES+1 cycles after edge N.
- Output stability: op_A_out, op_B_out and conv_status change only in CONVERT or on reset. They keep their last values after HOLD.
- Conversion, per operand (s, e8[7:0], m23[22:0]):
  - Zero: e8=0 and m23=0 → {s, 31'b0}, exact.
  - Normal: 97 ≤ e8 ≤ 158 → exp6 = e8-96 (range 1..62), mant = {m23, 2'b00}, exact.
  - Underflow: e8 < 97, including denormals → {s, 31'b0}, underflow.
  - Overflow: e8 > 158, including Inf/NaN → {s, 6'd62, 25'h1FFFFFF} (saturated), overflow.
- Exp 63 is never emitted; the FPU treats it as overflow.
- conv_status combines both operands with priority overflow > underflow > exact.

Decomposition:
- fpu_pkg holds:
  - field widths: SIGN=1, EXP=6, MANT=25
  - IEEE_BIAS=127, FPU_BIAS=31, REBIAS=96, EXP_MIN=1, EXP_MAX=62
  - status codes: ST_EXACT=4'b0001, ST_OVERFLOW=4'b0100, ST_UNDERFLOW=4'b1000
  - loader state enum: COLLECT, CONVERT, HOLD
- Sub-module ieee_to_fpu_fmt: combinational converter (32-bit IEEE in, 32-bit word + 4-bit status out), instantiated twice.

Test Plan:
- Bytes 3F 80 00 00 40 00 00 00 (1.0, 2.0) → op_A_out=0x3E000000, op_B_out=0x40000000, conv_status=0001; op_valid high exactly 32 cycles.
- A=C0400000 (-3.0), B=00000000 → op_A_out=0xC1000000, op_B_out=0x00000000, conv_status=0001.
- A=7F800000 (+Inf), B=00800000 → op_A_out=0x7DFFFFFF, op_B_out=0x00000000, conv_status=0100 (overflow wins).
- Range edges:
  - e8=97: A=30800000 → 0x02000000, exact.
  - e8=158: B=4F000000 → 0x7C000000, exact.
  - e8=159: 4F800000 → overflow.
- During HOLD, drive in_valid=1 with bytes AA every cycle → in_ready=0, outputs unchanged; the next pair collects correctly starting from byte 0.
- Assert reset after 5 accepted bytes → outputs all 0, op_valid=0, conv_status=0000; a full 8-byte sequence afterwards converts correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU operand loader.
//   - field widths of the FPU internal word (sign / exponent / mantissa)
//   - exponent biases and the legal FPU exponent range
//   - one-hot conversion status codes and the status merge helper
//   - loader state encoding
package fpu_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;

  localparam int IEEE_BIAS = 127;
  localparam int FPU_BIAS  = 31;
  localparam int REBIAS    = IEEE_BIAS - FPU_BIAS;  // 96
  localparam int EXP_MIN   = 1;
  localparam int EXP_MAX   = 62;                    // 63 is reserved for overflow in the FPU

  // IEEE biased exponents that map onto EXP_MIN..EXP_MAX
  localparam logic [7:0] IEEE_EXP_LO = 8'(REBIAS + EXP_MIN);  // 97
  localparam logic [7:0] IEEE_EXP_HI = 8'(REBIAS + EXP_MAX);  // 158

  localparam logic [3:0] ST_NONE      = 4'b0000;
  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } loader_state_e;

  // Merge the per-operand statuses: overflow beats underflow beats exact.
  function automatic logic [3:0] combine_status(input logic [3:0] st_a, input logic [3:0] st_b);
    logic [3:0] res;
    if ((st_a == ST_OVERFLOW) || (st_b == ST_OVERFLOW)) begin
      res = ST_OVERFLOW;
    end else if ((st_a == ST_UNDERFLOW) || (st_b == ST_UNDERFLOW)) begin
      res = ST_UNDERFLOW;
    end else begin
      res = ST_EXACT;
    end
    return res;
  endfunction

endpackage

// File: rtl/ieee_to_fpu_fmt.sv
// ieee_to_fpu_fmt: combinational IEEE-754 single -> FPU internal word converter.
//   ieee   in  32  IEEE-754 single-precision value
//   word   out 32  {sign, exp6 (bias 31), mant25 (implicit 1, m23 left-aligned)}
//   status out 4   one-hot ST_EXACT / ST_OVERFLOW / ST_UNDERFLOW
// Out-of-range exponents saturate (overflow) or flush to signed zero (underflow).
module ieee_to_fpu_fmt
  import fpu_pkg::*;
(
  input  logic [31:0] ieee,
  output logic [31:0] word,
  output logic [3:0]  status
);

  logic        sign_s;
  logic [7:0]  e8_s;
  logic [22:0] m23_s;
  logic [5:0]  exp6_s;

  assign sign_s = ieee[31];
  assign e8_s   = ieee[30:23];
  assign m23_s  = ieee[22:0];
  // Only meaningful in the normal range, where e8-96 lies in 1..62
  assign exp6_s = 6'(e8_s - 8'(REBIAS));

  // Classify the operand and build the rebiased word
  always_comb begin
    word   = 32'd0;
    status = ST_EXACT;
    if ((e8_s == 8'd0) && (m23_s == 23'd0)) begin
      word   = {sign_s, 31'd0};
      status = ST_EXACT;
    end else if (e8_s < IEEE_EXP_LO) begin
      // includes denormals
      word   = {sign_s, 31'd0};
      status = ST_UNDERFLOW;
    end else if (e8_s > IEEE_EXP_HI) begin
      // includes Inf/NaN
      word   = {sign_s, 6'(EXP_MAX), 25'h1FF_FFFF};
      status = ST_OVERFLOW;
    end else begin
      word   = {sign_s, exp6_s, m23_s, 2'b00};
      status = ST_EXACT;
    end
  end

endmodule

// File: rtl/fpu_operand_loader.sv
// fpu_operand_loader: byte-stream input stage for the FPU adder.
//   clock100KHz in  1   system clock, rising edge
//   reset       in  1   asynchronous, active-high
//   in_byte     in  8   operand bytes, MSB first, operand A then B
//   in_valid    in  1   in_byte valid
//   in_ready    out 1   byte accepted this cycle when in_valid is high
//   op_A_out    out 32  converted operand A
//   op_B_out    out 32  converted operand B
//   op_valid    out 1   operands fresh and held stable (HOLD_CYCLES cycles)
//   conv_status out 4   merged one-hot conversion status
//   busy        out 1   high while converting or holding
// Operands are held for a fixed window so the FPU's variable-length
// iteration always sees constant inputs; bytes offered meanwhile are dropped.
module fpu_operand_loader
  import fpu_pkg::*;
#(
  parameter int HOLD_CYCLES  = 32,
  parameter int BYTES_PER_OP = 4
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  output logic        op_valid,
  output logic [3:0]  conv_status,
  output logic        busy
);

  localparam int CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam int BCNT_W    = $clog2(2 * BYTES_PER_OP);
  localparam int LAST_BYTE = 2 * BYTES_PER_OP - 1;

  loader_state_e     state_r;
  logic [BCNT_W-1:0] byte_cnt_r;
  logic [31:0]       shift_a_r;
  logic [31:0]       shift_b_r;
  logic [CNT_W-1:0]  hold_cnt_r;

  logic [31:0] conv_a_s;
  logic [31:0] conv_b_s;
  logic [3:0]  st_a_s;
  logic [3:0]  st_b_s;
  logic        take_s;

  assign take_s = in_valid && in_ready;

  ieee_to_fpu_fmt u_conv_a (
    .ieee   (shift_a_r),
    .word   (conv_a_s),
    .status (st_a_s)
  );

  ieee_to_fpu_fmt u_conv_b (
    .ieee   (shift_b_r),
    .word   (conv_b_s),
    .status (st_b_s)
  );

  // Loader FSM: collect bytes, register converted pair, hold it stable
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_r     <= COLLECT;
      byte_cnt_r  <= '0;
      shift_a_r   <= 32'd0;
      shift_b_r   <= 32'd0;
      hold_cnt_r  <= '0;
      op_A_out    <= 32'd0;
      op_B_out    <= 32'd0;
      op_valid    <= 1'b0;
      conv_status <= ST_NONE;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          in_ready <= 1'b1;
          if (take_s) begin
            if (byte_cnt_r < BCNT_W'(BYTES_PER_OP)) begin
              shift_a_r <= {shift_a_r[23:0], in_byte};
            end else begin
              shift_b_r <= {shift_b_r[23:0], in_byte};
            end
            if (byte_cnt_r == BCNT_W'(LAST_BYTE)) begin
              byte_cnt_r <= '0;
              state_r    <= CONVERT;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end else begin
              byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
            end
          end
        end
        CONVERT: begin
          op_A_out    <= conv_a_s;
          op_B_out    <= conv_b_s;
          conv_status <= combine_status(st_a_s, st_b_s);
          op_valid    <= 1'b1;
          hold_cnt_r  <= CNT_W'(HOLD_CYCLES - 1);
          state_r     <= HOLD;
          in_ready    <= 1'b0;
          busy        <= 1'b1;
        end
        HOLD: begin
          in_ready <= 1'b0;
          if (hold_cnt_r == '0) begin
            state_r  <= COLLECT;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r    <= COLLECT;
          byte_cnt_r <= '0;
          op_valid   <= 1'b0;
          busy       <= 1'b0;
          in_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// tb_fpu_operand_loader: directed-vector bench for fpu_operand_loader.
// Stimulus pushes the hand-computed expected pair into a scoreboard queue;
// a negedge monitor pops it when op_valid rises and checks the hold window.
module tb_fpu_operand_loader;

  localparam int HOLD_CYCLES = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  st;
  } exp_t;

  logic        clock100KHz;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic        op_valid;
  logic [3:0]  conv_status;
  logic        busy;

  int errors = 0;
  int checks = 0;

  exp_t sb_q[$];

  fpu_operand_loader #(.HOLD_CYCLES(HOLD_CYCLES), .BYTES_PER_OP(4)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_A_out    (op_A_out),
    .op_B_out    (op_B_out),
    .op_valid    (op_valid),
    .conv_status (conv_status),
    .busy        (busy)
  );

  initial clock100KHz = 1'b0;
  always #5 clock100KHz = ~clock100KHz;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endfunction

  // Monitor: pop expected pair on op_valid rise, check stability and window length
  logic        prev_v = 1'b0;
  int          hold_len = 0;
  logic [31:0] cap_a, cap_b;
  logic [3:0]  cap_st;
  always @(negedge clock100KHz) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (op_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op_valid: got 1 expected 0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("op_A", op_A_out, e.a);
          chk("op_B", op_B_out, e.b);
          chk("conv_status", {28'd0, conv_status}, {28'd0, e.st});
        end
        cap_a = op_A_out;
        cap_b = op_B_out;
        cap_st = conv_status;
        hold_len = 1;
      end else if (op_valid && prev_v) begin
        hold_len++;
        chk("hold_A_stable", op_A_out, cap_a);
        chk("hold_B_stable", op_B_out, cap_b);
        chk("hold_st_stable", {28'd0, conv_status}, {28'd0, cap_st});
      end else if (!op_valid && prev_v) begin
        chk("op_valid_len", 32'(hold_len), 32'(HOLD_CYCLES));
      end
      if (op_valid) begin
        chk("in_ready_in_hold", {31'd0, in_ready}, 32'd0);
        chk("busy_in_hold", {31'd0, busy}, 32'd1);
      end
      prev_v = op_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    int n = 0;
    while (!done) begin
      @(negedge clock100KHz);
      in_valid = 1'b1;
      in_byte  = b;
      if (in_ready) begin
        @(posedge clock100KHz);
        #1 in_valid = 1'b0;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: got 0 expected 1");
          in_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] est);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.st = est;
    sb_q.push_back(e);
    send_word(a);
    send_word(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || op_valid || busy) && n < 500) begin
      @(negedge clock100KHz);
      n++;
    end
    chk("idle_reached", 32'(n < 500), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(negedge clock100KHz);
    chk("rst_op_A", op_A_out, 32'd0);
    chk("rst_op_B", op_B_out, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_status", {28'd0, conv_status}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock100KHz);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    send_pair(32'h3F80_0000, 32'h4000_0000, 32'h3E00_0000, 32'h4000_0000, 4'b0001);
    send_pair(32'hC040_0000, 32'h0000_0000, 32'hC100_0000, 32'h0000_0000, 4'b0001);
    send_pair(32'h7F80_0000, 32'h0080_0000, 32'h7DFF_FFFF, 32'h0000_0000, 4'b0100);
    send_pair(32'h3080_0000, 32'h4F00_0000, 32'h0200_0000, 32'h7C00_0000, 4'b0001);
    send_pair(32'h4F80_0000, 32'h3F80_0000, 32'h7DFF_FFFF, 32'h3E00_0000, 4'b0100);
    send_pair(32'h0080_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3E00_0000, 4'b1000);

    // Offer junk bytes throughout CONVERT/HOLD; none may be taken
    for (int i = 0; i < 100; i++) begin
      @(negedge clock100KHz);
      if (busy) begin
        in_valid = 1'b1;
        in_byte  = 8'hAA;
      end else begin
        in_valid = 1'b0;
        break;
      end
    end
    chk("post_hold_A_kept", op_A_out, 32'h0000_0000);
    chk("post_hold_B_kept", op_B_out, 32'h3E00_0000);
    chk("post_hold_in_ready", {31'd0, in_ready}, 32'd1);
    send_pair(32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0001);
    wait_idle();

    // Reset in the middle of a collection
    send_word(32'h3F80_0000);
    send_byte(8'h40);
    @(negedge clock100KHz);
    #2 reset = 1'b1;
    #1;
    chk("midrst_op_A", op_A_out, 32'd0);
    chk("midrst_op_B", op_B_out, 32'd0);
    chk("midrst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("midrst_status", {28'd0, conv_status}, 32'd0);
    @(negedge clock100KHz);
    reset = 1'b0;
    send_pair(32'hC040_0000, 32'h3080_0000, 32'hC100_0000, 32'h0200_0000, 4'b0001);
    wait_idle();
    chk("final_A_kept", op_A_out, 32'hC100_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
